// File: rtl/kart_net_pkg.sv
// Shared definitions for the kart link framer and its receiver: payload layout,
// framing constants, CRC constants and the transmit state encoding.
package kart_net_pkg;

  localparam int PAYLOAD_W  = 44;
  localparam int P_X_MSB    = 43;
  localparam int P_X_LSB    = 33;
  localparam int P_Y_MSB    = 31;
  localparam int P_Y_LSB    = 21;
  localparam int P_DIR_MSB  = 19;
  localparam int P_DIR_LSB  = 11;
  localparam int P_GAME_MSB = 7;
  localparam int P_GAME_LSB = 5;
  localparam int P_RST_BIT  = 3;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_PREAMBLE,
    TX_HEADER,
    TX_PAYLOAD,
    TX_FCS,
    TX_IFG
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0] SFD_BYTE       = 8'hD5;
  localparam int         PREAMBLE_BYTES = 8;
  localparam int         HEADER_BYTES   = 14;
  localparam int         PAYLOAD_BYTES  = 6;
  localparam int         MIN_PAYLOAD    = 46;
  localparam int         FCS_BYTES      = 4;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

  function automatic logic [PAYLOAD_W-1:0] pack_state(
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [8:0]  dir,
    input logic [2:0]  game,
    input logic        rst_flag
  );
    logic [PAYLOAD_W-1:0] p;
    p                        = '0;
    p[P_X_MSB:P_X_LSB]       = x;
    p[P_Y_MSB:P_Y_LSB]       = y;
    p[P_DIR_MSB:P_DIR_LSB]   = dir;
    p[P_GAME_MSB:P_GAME_LSB] = game;
    p[P_RST_BIT]             = rst_flag;
    return p;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Ethernet CRC-32 (reflected) advanced two bits per clock, bit 0 of the dibit first.
// Shared by the transmit framer and the receive FCS checker.
module crc32_dibit
  import kart_net_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear,
  input  logic        enable,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_q;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return (c[0] ^ b) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
  endfunction

  always_ff @(posedge clk_in) begin
    if (!rst_in || clear) begin
      crc_q <= CRC_INIT;
    end else if (enable) begin
      crc_q <= crc_bit(crc_bit(crc_q, dibit[0]), dibit[1]);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/game_state_tx.sv
// RMII transmit framer: packs the local player state into the 44-bit game word
// and sends it as one Ethernet II frame of dibits, followed by an idle gap.
module game_state_tx
  import kart_net_pkg::*;
#(
  parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [47:0] SRC_MAC    = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5,
  parameter int          IFG_CYCLES = 48
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        send_in,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        reset_flag,
  output logic        eth_txen,
  output logic [1:0]  eth_txd,
  output logic        busy_out,
  output logic        done_out
);

  localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [5:0]   PRE_LAST = 6'(PREAMBLE_BYTES - 1);
  localparam logic [5:0]   HDR_LAST = 6'(HEADER_BYTES - 1);
  localparam logic [5:0]   PAY_LAST = 6'(MIN_PAYLOAD - 1);
  localparam logic [5:0]   PAY_DATA = 6'(PAYLOAD_BYTES);
  localparam logic [5:0]   FCS_LAST = 6'(FCS_BYTES - 1);
  localparam logic [7:0]   IFG_LAST = 8'(IFG_CYCLES - 1);

  tx_state_t   state_q, state_d;
  logic [5:0]  byte_q, byte_d;
  logic [1:0]  dib_q, dib_d;
  logic        pending_q, pending_d;
  logic [47:0] word_q;
  logic        last_dibit, launch;

  logic [7:0]  cur_byte;
  logic [6:0]  hdr_idx;
  logic [5:0]  word_idx;
  logic [31:0] crc, fcs;
  logic        txen_d, done_d;
  logic [1:0]  txd_d;
  logic        txen_q, done_q;
  logic [1:0]  txd_q;

  always_comb begin
    last_dibit = 1'b0;
    case (state_q)
      TX_PREAMBLE: last_dibit = (byte_q == PRE_LAST) && (dib_q == 2'd3);
      TX_HEADER:   last_dibit = (byte_q == HDR_LAST) && (dib_q == 2'd3);
      TX_PAYLOAD:  last_dibit = (byte_q == PAY_LAST) && (dib_q == 2'd3);
      TX_FCS:      last_dibit = (byte_q == FCS_LAST) && (dib_q == 2'd3);
      TX_IFG:      last_dibit = ({byte_q, dib_q} == IFG_LAST);
      default:     last_dibit = 1'b0;
    endcase
  end

  // A request arriving on the final gap cycle rides along with the pending launch.
  assign launch = ((state_q == TX_IDLE) && send_in) ||
                  ((state_q == TX_IFG) && last_dibit && (pending_q || send_in));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= TX_IDLE;
      byte_q    <= '0;
      dib_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      dib_q     <= dib_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (launch) begin
      word_q <= {pack_state(player_x, player_y, direction, game_stat, reset_flag), 4'b0000};
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    dib_d     = dib_q + 2'd1;
    byte_d    = (dib_q == 2'd3) ? byte_q + 6'd1 : byte_q;
    if (launch) begin
      pending_d = 1'b0;
    end else if (send_in && (state_q != TX_IDLE)) begin
      pending_d = 1'b1;
    end
    case (state_q)
      TX_IDLE:     if (launch)     state_d = TX_PREAMBLE;
      TX_PREAMBLE: if (last_dibit) state_d = TX_HEADER;
      TX_HEADER:   if (last_dibit) state_d = TX_PAYLOAD;
      TX_PAYLOAD:  if (last_dibit) state_d = TX_FCS;
      TX_FCS:      if (last_dibit) state_d = TX_IFG;
      TX_IFG:      if (last_dibit) state_d = launch ? TX_PREAMBLE : TX_IDLE;
      default:     state_d = TX_IDLE;
    endcase
    if ((state_q == TX_IDLE) || last_dibit) begin
      dib_d  = '0;
      byte_d = '0;
    end
  end

  assign hdr_idx  = 7'd104 - {byte_q[3:0], 3'b000};
  assign word_idx = 6'd40 - {byte_q[2:0], 3'b000};
  assign fcs      = ~crc;

  always_comb begin
    cur_byte = 8'h00;
    txen_d   = 1'b1;
    done_d   = 1'b0;
    case (state_q)
      TX_PREAMBLE: cur_byte = (byte_q == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
      TX_HEADER:   cur_byte = HDR[hdr_idx +: 8];
      TX_PAYLOAD:  cur_byte = (byte_q < PAY_DATA) ? word_q[word_idx +: 8] : 8'h00;
      TX_FCS: begin
        cur_byte = fcs[{byte_q[1:0], 3'b000} +: 8];
        done_d   = last_dibit;
      end
      default:     txen_d = 1'b0;
    endcase
    txd_d = txen_d ? cur_byte[{dib_q, 1'b0} +: 2] : 2'b00;
  end

  crc32_dibit u_crc (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clear  (state_q == TX_PREAMBLE),
    .enable ((state_q == TX_HEADER) || (state_q == TX_PAYLOAD)),
    .dibit  (txd_d),
    .crc    (crc)
  );

  // Output register: the PHY sees each dibit one cycle after it is selected.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      txen_q <= 1'b0;
      txd_q  <= 2'b00;
      done_q <= 1'b0;
    end else begin
      txen_q <= txen_d;
      txd_q  <= txd_d;
      done_q <= done_d;
    end
  end

  assign eth_txen = txen_q;
  assign eth_txd  = txd_q;
  assign done_out = done_q;
  assign busy_out = (state_q != TX_IDLE);

endmodule

// File: tb/tb_game_state_tx.sv
// Directed and randomized checks of game_state_tx against a byte-level frame model.
module tb_game_state_tx;
  import kart_net_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        send_in = 1'b0;
  logic [10:0] player_x = '0;
  logic [10:0] player_y = '0;
  logic [8:0]  direction = '0;
  logic [2:0]  game_stat = '0;
  logic        reset_flag = 1'b0;
  logic        eth_txen;
  logic [1:0]  eth_txd;
  logic        busy_out;
  logic        done_out;

  game_state_tx dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .send_in    (send_in),
    .player_x   (player_x),
    .player_y   (player_y),
    .direction  (direction),
    .game_stat  (game_stat),
    .reset_flag (reset_flag),
    .eth_txen   (eth_txen),
    .eth_txd    (eth_txd),
    .busy_out   (busy_out),
    .done_out   (done_out)
  );

  always #10 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  int total = 0;
  int bad = 0;

  // Frame capture on the falling edge.
  logic       prev_en = 1'b0;
  logic [1:0] cap [0:511];
  logic [1:0] last_frame [0:511];
  int         cap_n = 0;
  int         last_len = 0;
  int         nframes = 0;
  int         rise_cyc[$];
  int         len_q[$];
  int         done_cyc[$];

  always @(negedge clk_in) begin
    if (eth_txen === 1'b1) begin
      if (!prev_en) begin
        rise_cyc.push_back(cyc);
        cap_n = 0;
      end
      if (cap_n < 512) cap[cap_n] = eth_txd;
      cap_n++;
    end else if (prev_en) begin
      for (int i = 0; i < 512; i++) last_frame[i] = cap[i];
      last_len = cap_n;
      len_q.push_back(cap_n);
      nframes++;
    end
    if (done_out === 1'b1) done_cyc.push_back(cyc);
    prev_en = (eth_txen === 1'b1);
  end

  // Reference frame built byte by byte from the frame format.
  logic [7:0]  exp_bytes [0:71];
  logic [1:0]  exp_dib [0:287];
  logic [31:0] exp_fcs;

  task automatic build_model(input int x, input int y, input int d, input int g, input int r);
    longint unsigned w;
    longint unsigned src;
    logic [31:0] c;
    src = 64'h0000_6969_5A06_5491;
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h55;
    exp_bytes[7] = 8'hD5;
    for (int i = 0; i < 6; i++) begin
      exp_bytes[8 + i]  = 8'hFF;
      exp_bytes[14 + i] = 8'((src >> (40 - 8 * i)) & 64'hFF);
    end
    exp_bytes[20] = 8'h88;
    exp_bytes[21] = 8'hB5;
    w = (longint'(x) << 37) + (longint'(y) << 25) + (longint'(d) << 15) +
        (longint'(g) << 9) + (longint'(r) << 7);
    for (int i = 0; i < 6; i++) exp_bytes[22 + i] = 8'((w >> (40 - 8 * i)) & 64'hFF);
    for (int i = 28; i < 68; i++) exp_bytes[i] = 8'h00;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 68; i++) begin
      c = c ^ {24'h0, exp_bytes[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    exp_fcs = ~c;
    for (int i = 0; i < 4; i++) exp_bytes[68 + i] = 8'((exp_fcs >> (8 * i)) & 32'hFF);
    for (int i = 0; i < 288; i++) exp_dib[i] = 2'((exp_bytes[i / 4] >> (2 * (i % 4))) & 8'h3);
  endtask

  function automatic logic [7:0] cap_byte(input int i);
    return {last_frame[4*i+3], last_frame[4*i+2], last_frame[4*i+1], last_frame[4*i]};
  endfunction

  function automatic int rise_at(input int k);
    return (k < rise_cyc.size()) ? rise_cyc[k] : -1;
  endfunction

  function automatic int len_at(input int k);
    return (k < len_q.size()) ? len_q[k] : -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_frames(input int target, input int budget);
    int b;
    b = budget;
    while ((nframes < target) && (b > 0)) begin
      tick();
      b--;
    end
    chk("frame_arrival", 64'(nframes >= target), 64'd1);
  endtask

  task automatic set_inputs(input int x, input int y, input int d, input int g, input int r);
    player_x   = 11'(x);
    player_y   = 11'(y);
    direction  = 9'(d);
    game_stat  = 3'(g);
    reset_flag = 1'(r);
  endtask

  task automatic send(input int x, input int y, input int d, input int g, input int r,
                      output int n);
    set_inputs(x, y, d, g, r);
    send_in = 1'b1;
    n = cyc + 1;
    tick();
    send_in = 1'b0;
  endtask

  task automatic pulse();
    send_in = 1'b1;
    tick();
    send_in = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int errs;
    errs = 0;
    for (int i = 0; i < 288; i++) if (last_frame[i] !== exp_dib[i]) errs++;
    chk({tag, "_len"}, 64'(last_len), 64'd288);
    chk({tag, "_dibit_errors"}, 64'(errs), 64'd0);
  endtask

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31 - i];
    return r;
  endfunction

  initial begin
    int n, fb, rb;
    int rx, ry, rd, rg, rr;
    logic [31:0] c;

    // Reset state
    repeat (3) tick();
    chk("rst_txen", 64'(eth_txen), 64'd0);
    chk("rst_txd", 64'(eth_txd), 64'd0);
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    rst_in = 1'b1;
    tick();

    // Frame 1: reference state
    build_model(191, 191, 270, 1, 0);
    send(191, 191, 270, 1, 0, n);
    chk("busy_on_accept", 64'(busy_out), 64'd1);
    chk("txen_not_yet", 64'(eth_txen), 64'd0);
    wait_frames(1, 400);
    chk("f1_rise", 64'(rise_at(0)), 64'(n + 1));
    check_frame("f1");
    chk("f1_payload", {cap_byte(22), cap_byte(23), cap_byte(24), cap_byte(25),
                       cap_byte(26), cap_byte(27)}, 64'h17E1_7E87_0200);
    chk("f1_first_dibits", {last_frame[88], last_frame[89], last_frame[90], last_frame[91]},
        {2'd3, 2'd1, 2'd1, 2'd0});
    chk("f1_done", 64'(done_cyc.size() > 0 ? done_cyc[0] : -1), 64'(n + 288));
    wait_until(n + 335);
    chk("busy_in_gap", 64'(busy_out), 64'd1);
    wait_until(n + 336);
    chk("busy_after_gap", 64'(busy_out), 64'd0);

    // Frame 2: reset flag set, inputs disturbed mid-payload
    build_model(191, 191, 270, 1, 1);
    send(191, 191, 270, 1, 1, n);
    wait_until(n + 100);
    player_x = 11'd0;
    player_y = 11'd5;
    wait_frames(2, 400);
    check_frame("f2");
    chk("f2_byte5", 64'(cap_byte(27)), 64'h80);
    chk("f2_x_held", 64'(cap_byte(22)), 64'h17);
    chk("f2_fcs", {cap_byte(71), cap_byte(70), cap_byte(69), cap_byte(68)}, 64'(exp_fcs));
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 72; i++) begin
      c = c ^ {24'h0, cap_byte(i)};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    // The shift-right register holds the residue in reflected bit order.
    chk("f2_residue", 64'(bitrev32(c)), 64'(CRC_RESIDUE));
    wait_until(n + 340);

    // Two requests during a frame yield exactly one extra frame
    fb = nframes;
    rb = rise_cyc.size();
    rx = $urandom_range(0, 2047); ry = $urandom_range(0, 2047);
    rd = $urandom_range(0, 359);  rg = $urandom_range(0, 7); rr = $urandom_range(0, 1);
    build_model(rx, ry, rd, rg, rr);
    send(rx, ry, rd, rg, rr, n);
    wait_until(n + 10);
    pulse();
    wait_until(n + 100);
    pulse();
    rx = $urandom_range(0, 2047); ry = $urandom_range(0, 2047);
    rd = $urandom_range(0, 359);  rg = $urandom_range(0, 7); rr = $urandom_range(0, 1);
    set_inputs(rx, ry, rd, rg, rr);
    wait_frames(fb + 1, 400);
    check_frame("pend_a");
    build_model(rx, ry, rd, rg, rr);
    wait_frames(fb + 2, 400);
    check_frame("pend_b");
    chk("pend_rise", 64'(rise_at(rb + 1)), 64'(n + 337));
    wait_until(n + 336 * 2 + 100);
    chk("pend_count", 64'(nframes - fb), 64'd2);

    // Randomized single frames
    for (int k = 0; k < 3; k++) begin
      rx = $urandom_range(0, 2047); ry = $urandom_range(0, 2047);
      rd = $urandom_range(0, 359);  rg = $urandom_range(0, 7); rr = $urandom_range(0, 1);
      build_model(rx, ry, rd, rg, rr);
      fb = nframes;
      send(rx, ry, rd, rg, rr, n);
      wait_frames(fb + 1, 400);
      check_frame("rand");
      wait_until(n + 337);
    end

    // Reset during the frame, with a request pending
    rb = rise_cyc.size();
    send(191, 191, 270, 1, 0, n);
    wait_until(n + 50);
    pulse();
    wait_until(n + 151);
    rst_in = 1'b0;
    tick();
    chk("abort_txen", 64'(eth_txen), 64'd0);
    chk("abort_busy", 64'(busy_out), 64'd0);
    chk("abort_txd", 64'(eth_txd), 64'd0);
    tick();
    rst_in = 1'b1;
    repeat (800) tick();
    chk("abort_no_resume", 64'(rise_cyc.size() - rb), 64'd1);
    chk("abort_len", 64'(len_at(rb)), 64'd151);
    chk("abort_idle", 64'(busy_out), 64'd0);

    // 100 consecutive request cycles
    rb = rise_cyc.size();
    send_in = 1'b1;
    n = cyc + 1;
    repeat (100) tick();
    send_in = 1'b0;
    wait_until(n + 336 * 2 + 50);
    chk("b2b_count", 64'(rise_cyc.size() - rb), 64'd2);
    chk("b2b_spacing", 64'(rise_at(rb + 1) - rise_at(rb)), 64'd336);
    chk("b2b_gap", 64'(rise_at(rb + 1) - rise_at(rb) - len_at(rb)), 64'd48);

    // Requests held high long enough to chain several frames
    rb = rise_cyc.size();
    send_in = 1'b1;
    n = cyc + 1;
    repeat (700) tick();
    send_in = 1'b0;
    wait_until(n + 336 * 4 + 50);
    chk("chain_count", 64'(rise_cyc.size() - rb), 64'd4);
    chk("chain_first", 64'(rise_at(rb)), 64'(n + 1));
    for (int k = 1; k < 4; k++) begin
      chk("chain_spacing", 64'(rise_at(rb + k) - rise_at(rb + k - 1)), 64'd336);
      chk("chain_gap", 64'(rise_at(rb + k) - rise_at(rb + k - 1) - len_at(rb + k - 1)), 64'd48);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_state_tx.md
Name: game_state_tx

Overview:
- RMII transmit-side framer for the two-player kart link. The receive path decodes the same frame format back into the 44-bit opponent word.
- On a send request it latches the local player state (x, y, direction, game status, reset flag) and packs it into the shared 44-bit game-state word.
- It wraps the word in an Ethernet II frame (preamble, SFD, MACs, ethertype, padded payload, FCS) and shifts the frame out as dibits on eth_txd/eth_txen.
- Runs entirely in the 50 MHz eth_refclk domain and sits between the game logic and the PHY pins in top_level.

Parameters:
- DST_MAC, 48'hFF_FF_FF_FF_FF_FF: destination MAC, sent MSB byte first.
- SRC_MAC, 48'h69_69_5A_06_54_91: source MAC, sent MSB byte first.
- ETHERTYPE, 16'h88B5: type field, sent MSB byte first.
- IFG_CYCLES, 48: idle cycles after each frame (12 bytes x 4 dibits).

Ports:
- clk_in  input  1  eth_refclk, 50 MHz.
- rst_in  input  1  reset, synchronous, active-low.
- send_in  input  1  single-cycle request to transmit current state.
- player_x  input  11  local x position.
- player_y  input  11  local y position.
- direction  input  9  heading, degrees 0-359.
- game_stat  input  3  game status code.
- reset_flag  input  1  asks the opponent to reset.
- eth_txen  output  1  RMII transmit enable.
- eth_txd  output  2  RMII transmit dibit.
- busy_out  output  1  high whenever state != IDLE.
- done_out  output  1  one-cycle pulse on the last FCS dibit.

Behaviour:
- Reset values: state IDLE, eth_txen=0, eth_txd=0, busy_out=0, done_out=0, pending=0. Reset asserted mid-frame drops eth_txen on the next edge; no truncated-frame recovery.
- Payload word P[43:0]:
  - P[43:33]=x, P[32]=0
  - P[31:21]=y, P[20]=0
  - P[19:11]=dir, P[10:8]=0
  - P[7:5]=game, P[4]=0
  - P[3]=reset_flag, P[2:0]=0
- Payload is sent as the 6 bytes of {P,4'b0}, MSB byte first, followed by 40 zero pad bytes (46-byte minimum).
- Inputs are latched on the cycle send_in is accepted. Later input changes do not affect the frame in flight.
- Byte serialization: LSB dibit first ({b[1:0]}, {b[3:2]}, {b[5:4]}, {b[7:6]}). Exactly one dibit per clock.
- States and dibit counts:
  - IDLE
  - PREAMBLE: 28 dibits of 2'b01, then SFD 0xD5 (4 dibits) -> 32 total.
  - HEADER: 56 dibits (DST, SRC, ETHERTYPE).
  - PAYLOAD: 184 dibits.
  - FCS: 16 dibits.
  - IFG: IFG_CYCLES cycles, eth_txen=0.
  - Then back to IDLE.
- eth_txen is high for exactly 288 consecutive cycles per frame.
- Latency: send_in high in IDLE at edge N gives eth_txen=1 with the first preamble dibit after edge N+1. Outputs are registered.
- FCS: CRC-32, reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated 2 bits per cycle over HEADER+PAYLOAD dibits only.
  - Transmitted as the complement, LSB first.
- Request handling:
  - send_in while busy sets a 1-deep pending flag; further requests while pending are dropped.
  - Pending launches a frame on the cycle IDLE is re-entered after IFG; inputs are sampled then.
  - send_in on the same cycle as a pending launch is absorbed into that launch (no extra frame).
- Counters: one byte counter (max 45) and one 2-bit dibit index. Both wrap to 0 at each state change.

Decomposition:
- Package kart_net_pkg holds:
  - the payload field bit positions, shared with the receiver,
  - the tx_state_t enum,
  - PREAMBLE_BYTE, SFD_BYTE, PAYLOAD_BYTES=6 and MIN_PAYLOAD=46,
  - CRC_POLY and CRC_RESIDUE=32'hC704DD7B.
- One sub-module, crc32_dibit: clk_in, rst_in, clear, enable, dibit in, 32-bit crc out. It is reusable by the receiver for FCS checking.

Test Plan:
- Reset, then send_in with x=191, y=191, dir=270, game=1, reset_flag=0 -> payload bytes 17 E1 7E 87 02 00. First payload dibits are 3,1,1,0. eth_txen is high for exactly 288 cycles.
- Same frame with reset_flag=1 -> sixth payload byte 0x80. Running CRC over bytes DST..FCS gives residue 0xC704DD7B. FCS matches the zlib crc32 of DST..pad.
- send_in pulsed at cycles 10 and 100 of a frame -> exactly one extra frame. Its eth_txen rises at cycle 288+48+1 relative to the first frame's start.
- Inputs changed to x=0 during PAYLOAD -> the frame in flight still carries x=191.
- rst_in low at dibit 150 -> eth_txen=0 next cycle; busy_out=0, and no frame resumes after release.
- 100 back-to-back send_in pulses on every cycle -> frames are spaced exactly 336 cycles apart. Gaps between frames are 48 cycles, never fewer.
